// File: rtl/tdm_ram_pkg.sv
// -----------------------------------------------------------------------------
// tdm_ram_pkg
// Shared constants and helpers for the TDM multiport RAM slice.
//   DEF_*        : default parameter values used by tdm_multiport_ram/rr_arbiter
//   PAR_MAX_W    : widest word the parity helper accepts
//   even_parity  : even-parity bit of a (zero-extended) data word
// Optional feature macro used by users of this package: TDM_RAM_PARITY_EN
// -----------------------------------------------------------------------------
package tdm_ram_pkg;

    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_ADDR_W = 8;
    localparam int unsigned DEF_DEPTH  = 256;
    localparam int unsigned DEF_NPORTS = 2;

    localparam int unsigned PAR_MAX_W  = 64;

    // Bit that makes the total number of ones (data + parity) even.
    function automatic logic even_parity(input logic [PAR_MAX_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter with combinational grant. The search starts at the port
// after the last granted one and wraps; the pointer only moves on a grant.
// After reset port 0 has highest priority.
//   clk   : clock
//   rst_n : asynchronous active-low reset (also forces gnt to zero)
//   req   : per-port request
//   gnt   : one-hot or zero grant, valid in the request cycle
// -----------------------------------------------------------------------------
module rr_arbiter
    import tdm_ram_pkg::*;
#(
    parameter int unsigned N = DEF_NPORTS
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);

    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] last_q;
    logic [PW-1:0] pick;
    logic [PW-1:0] idx;
    logic          found;

    always_comb begin
        gnt   = '0;
        pick  = last_q;
        idx   = '0;
        found = 1'b0;
        for (int unsigned k = 1; k <= N; k++) begin
            idx = PW'((32'(last_q) + k) % N);
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
        if (found && rst_n) begin
            gnt[pick] = 1'b1;
        end
    end

    // Reset points at the last port so the first search begins at port 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= PW'(N - 1);
        end else if (found) begin
            last_q <= pick;
        end
    end

endmodule

// File: rtl/tdm_multiport_ram.sv
// -----------------------------------------------------------------------------
// tdm_multiport_ram
// Single-port RAM shared by NPORTS requesters through a round-robin arbiter.
// One access per cycle; reads return one cycle after the grant on a shared
// rdata bus tagged by the one-hot rvalid. Out-of-range accesses are granted,
// writes are dropped and reads return zero.
//   clk, rst_n : clock, asynchronous active-low reset
//   req, we    : per-port request and write(1)/read(0) qualifier
//   addr       : per-port address, port i at [i*ADDR_W +: ADDR_W]
//   wdata      : per-port write data, port i at [i*DATA_W +: DATA_W]
//   gnt        : combinational one-hot grant
//   rvalid     : one-hot owner of rdata this cycle
//   rdata      : shared read data, held when rvalid is zero
//   rerr       : parity error, qualified by rvalid
// Optional feature macro: TDM_RAM_PARITY_EN (stores an even-parity bit per
// word and flags mismatches on read; otherwise rerr is tied low).
// -----------------------------------------------------------------------------
module tdm_multiport_ram
    import tdm_ram_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DEPTH  = DEF_DEPTH,
    parameter int unsigned NPORTS = DEF_NPORTS
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NPORTS-1:0]        req,
    input  logic [NPORTS-1:0]        we,
    input  logic [NPORTS*ADDR_W-1:0] addr,
    input  logic [NPORTS*DATA_W-1:0] wdata,
    output logic [NPORTS-1:0]        gnt,
    output logic [NPORTS-1:0]        rvalid,
    output logic [DATA_W-1:0]        rdata,
    output logic                     rerr
);

    localparam int unsigned PW  = (NPORTS > 1) ? $clog2(NPORTS) : 1;
    localparam int unsigned MAW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [NPORTS-1:0] gnt_w;
    logic [PW-1:0]     sel;
    logic              any_gnt;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              in_range;
    logic [MAW-1:0]    mem_idx;
    logic              do_wr;
    logic              do_rd;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [NPORTS-1:0] rvalid_q;
    logic [DATA_W-1:0] rdata_q;

    rr_arbiter #(.N(NPORTS)) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .gnt   (gnt_w)
    );

    assign gnt = gnt_w;

    always_comb begin
        sel = '0;
        for (int unsigned i = 0; i < NPORTS; i++) begin
            if (gnt_w[i]) begin
                sel = PW'(i);
            end
        end
    end

    assign any_gnt   = |gnt_w;
    assign sel_we    = we[sel];
    assign sel_addr  = addr[sel*ADDR_W +: ADDR_W];
    assign sel_wdata = wdata[sel*DATA_W +: DATA_W];
    // Extra MSB keeps the compare exact when DEPTH == 2**ADDR_W.
    assign in_range  = ({1'b0, sel_addr} < (ADDR_W+1)'(DEPTH));
    assign mem_idx   = sel_addr[MAW-1:0];
    assign do_wr     = any_gnt && sel_we && in_range;
    assign do_rd     = any_gnt && !sel_we;

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[mem_idx] <= sel_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_q <= '0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= '0;
            if (do_rd) begin
                rvalid_q <= gnt_w;
                rdata_q  <= in_range ? mem[mem_idx] : '0;
            end
        end
    end

    assign rvalid = rvalid_q;
    assign rdata  = rdata_q;

`ifdef TDM_RAM_PARITY_EN
    logic mem_par [DEPTH];
    logic rerr_q;

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_par[mem_idx] <= even_parity(PAR_MAX_W'(sel_wdata));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rerr_q <= 1'b0;
        end else begin
            rerr_q <= 1'b0;
            if (do_rd && in_range) begin
                rerr_q <= even_parity(PAR_MAX_W'(mem[mem_idx])) != mem_par[mem_idx];
            end
        end
    end

    assign rerr = rerr_q;
`else
    assign rerr = 1'b0;
`endif

endmodule

// File: tb/tb_tdm_multiport_ram.sv
// -----------------------------------------------------------------------------
// tb_tdm_multiport_ram
// Directed self-checking bench for tdm_multiport_ram (NPORTS=2, DEPTH=200).
// Honours TDM_RAM_PARITY_EN for the expected rerr after a corrupted word.
// -----------------------------------------------------------------------------
module tb_tdm_multiport_ram;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req;
    logic [1:0]  we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [1:0]  gnt;
    logic [1:0]  rvalid;
    logic [7:0]  rdata;
    logic        rerr;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    tdm_multiport_ram #(
        .DATA_W (8),
        .ADDR_W (8),
        .DEPTH  (200),
        .NPORTS (2)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .we     (we),
        .addr   (addr),
        .wdata  (wdata),
        .gnt    (gnt),
        .rvalid (rvalid),
        .rdata  (rdata),
        .rerr   (rerr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #50000;
        $error("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic [1:0] r, input logic [1:0] w,
                       input logic [7:0] a0, input logic [7:0] a1,
                       input logic [7:0] d0, input logic [7:0] d1);
        req   = r;
        we    = w;
        addr  = {a1, a0};
        wdata = {d1, d0};
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic par_exp;

    initial begin
`ifdef TDM_RAM_PARITY_EN
        par_exp = 1'b1;
`else
        par_exp = 1'b0;
`endif
        // Reset state, with requests pending to show gnt is forced low
        rst_n = 1'b0;
        drv(2'b11, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
        #12;
        chk("rst_gnt",    8'(gnt),    8'h00);
        chk("rst_rvalid", 8'(rvalid), 8'h00);
        chk("rst_rdata",  rdata,      8'h00);
        chk("rst_rerr",   8'(rerr),   8'h00);

        // Contention from reset: both ports write every cycle
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drv(2'b11, 2'b11, 8'h10, 8'h11, 8'hA0, 8'hA1);
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("contend_gnt", 8'(gnt), (i % 2 == 0) ? 8'h01 : 8'h02);
            tick();
        end
        chk("write_no_rvalid", 8'(rvalid), 8'h00);

        // Idle cycle must not move the pointer (last grant: port0)
        drv(2'b01, 2'b01, 8'h12, 8'h00, 8'h12, 8'h00);
        #1 chk("ptr_set_gnt", 8'(gnt), 8'h01);
        tick();
        drv(2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
        #1 chk("idle_gnt", 8'(gnt), 8'h00);
        tick();
        drv(2'b11, 2'b11, 8'h12, 8'h13, 8'h12, 8'h13);
        #1 chk("after_idle_gnt", 8'(gnt), 8'h02);
        tick();

        // Directed write/read
        drv(2'b01, 2'b01, 8'h00, 8'h00, 8'h55, 8'h00);
        #1 chk("wr55_gnt", 8'(gnt), 8'h01);
        tick();
        drv(2'b10, 2'b10, 8'h00, 8'h01, 8'h00, 8'hAA);
        #1 chk("wrAA_gnt", 8'(gnt), 8'h02);
        tick();
        drv(2'b10, 2'b00, 8'h00, 8'h01, 8'h00, 8'h00);
        #1 chk("rd01_gnt", 8'(gnt), 8'h02);
        tick();
        chk("rd01_rvalid", 8'(rvalid), 8'h02);
        chk("rd01_rdata",  rdata,      8'hAA);
        chk("rd01_rerr",   8'(rerr),   8'h00);
        drv(2'b01, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
        #1 chk("rd00_gnt", 8'(gnt), 8'h01);
        tick();
        chk("rd00_rvalid", 8'(rvalid), 8'h01);
        chk("rd00_rdata",  rdata,      8'h55);
        drv(2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
        tick();
        chk("hold_rvalid", 8'(rvalid), 8'h00);
        chk("hold_rdata",  rdata,      8'h55);

        // Read-after-write, back to back
        drv(2'b01, 2'b01, 8'h02, 8'h00, 8'h5A, 8'h00);
        #1 chk("raw_wr_gnt", 8'(gnt), 8'h01);
        tick();
        drv(2'b10, 2'b00, 8'h00, 8'h02, 8'h00, 8'h00);
        #1 chk("raw_rd_gnt", 8'(gnt), 8'h02);
        tick();
        chk("raw_rvalid", 8'(rvalid), 8'h02);
        chk("raw_rdata",  rdata,      8'h5A);

        // Last in-range word (199)
        drv(2'b01, 2'b01, 8'hC7, 8'h00, 8'h3C, 8'h00);
        tick();
        drv(2'b10, 2'b00, 8'h00, 8'hC7, 8'h00, 8'h00);
        tick();
        chk("c7_rvalid", 8'(rvalid), 8'h02);
        chk("c7_rdata",  rdata,      8'h3C);

        // Out of range (200): granted, write dropped, read returns zero
        drv(2'b01, 2'b01, 8'hC8, 8'h00, 8'h77, 8'h00);
        #1 chk("oor_wr_gnt", 8'(gnt), 8'h01);
        tick();
        drv(2'b10, 2'b00, 8'h00, 8'hC8, 8'h00, 8'h00);
        #1 chk("oor_rd_gnt", 8'(gnt), 8'h02);
        tick();
        chk("oor_rvalid", 8'(rvalid), 8'h02);
        chk("oor_rdata",  rdata,      8'h00);
        chk("oor_rerr",   8'(rerr),   8'h00);

        // Parity: clean read, then corrupt one stored bit and read again
        drv(2'b01, 2'b01, 8'h05, 8'h00, 8'h0F, 8'h00);
        tick();
        drv(2'b10, 2'b00, 8'h00, 8'h05, 8'h00, 8'h00);
        tick();
        chk("par_clean_rdata", rdata,    8'h0F);
        chk("par_clean_rerr",  8'(rerr), 8'h00);
        drv(2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
        dut.mem[5] = 8'h0E;
        #1;
        drv(2'b01, 2'b00, 8'h05, 8'h00, 8'h00, 8'h00);
        tick();
        chk("par_bad_rvalid", 8'(rvalid), 8'h01);
        chk("par_bad_rdata",  rdata,      8'h0E);
        chk("par_bad_rerr",   8'(rerr),   8'(par_exp));

        // Reset while a read is in flight (last grant port0)
        drv(2'b01, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
        #1 chk("mid_rd_gnt", 8'(gnt), 8'h01);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_gnt",    8'(gnt),    8'h00);
        chk("mid_rst_rvalid", 8'(rvalid), 8'h00);
        chk("mid_rst_rdata",  rdata,      8'h00);
        drv(2'b11, 2'b00, 8'h00, 8'h01, 8'h00, 8'h00);
        tick();
        chk("post_edge_rvalid", 8'(rvalid), 8'h00);
        chk("post_edge_rdata",  rdata,      8'h00);
        rst_n = 1'b1;
        #1 chk("post_rst_gnt", 8'(gnt), 8'h01);
        tick();
        chk("post_rst_rvalid", 8'(rvalid), 8'h01);
        chk("post_rst_rdata",  rdata,      8'h55);
        drv(2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tdm_multiport_ram.md
TDM_MULTIPORT_RAM -- requirements
Module: tdm_multiport_ram

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning the word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 8, meaning the address width in bits.
REQ-003 SHALL have parameter DEPTH, default 256, meaning the number of words, with DEPTH <= 2**ADDR_W.
REQ-004 SHALL have parameter NPORTS, default 2, meaning the number of request ports, with 2 <= NPORTS <= 8.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous reset, active low.
REQ-007 SHALL have port req, input, NPORTS bits: per-port access request.
REQ-008 SHALL have port we, input, NPORTS bits: per-port write (1) or read (0) qualifier.
REQ-009 SHALL have port addr, input, NPORTS*ADDR_W bits: per-port address; port i occupies slice [i*ADDR_W +: ADDR_W].
REQ-010 SHALL have port wdata, input, NPORTS*DATA_W bits: per-port write data, sliced the same way as addr.
REQ-011 SHALL have port gnt, output, NPORTS bits: one-hot or zero; combinational grant in the request cycle.
REQ-012 SHALL have port rvalid, output, NPORTS bits: one-hot or zero; marks the port that owns rdata this cycle.
REQ-013 SHALL have port rdata, output, DATA_W bits: shared read-data bus.
REQ-014 SHALL have port rerr, output, 1 bit: parity error flag, qualified by rvalid.

Function
REQ-015 SHALL provide a single-port memory array and grant at most one request per clk cycle.
REQ-016 SHALL select the granted port by round-robin: the search starts at the port after the last granted port and wraps from NPORTS-1 to 0.
REQ-017 SHALL treat req as held by the requester until gnt; an access completes in the cycle gnt=1, and a requester may drop req without penalty if it has not been granted.
REQ-018 SHALL, for a granted write with addr < DEPTH, store wdata at the clk edge closing the grant cycle.
REQ-019 SHALL, for a granted read, assert rvalid for that port and drive rdata exactly 1 cycle after the grant cycle, for one cycle.
REQ-020 SHALL hold rdata at its last value when rvalid is zero.
REQ-021 SHALL, for an out-of-range address (addr >= DEPTH), still grant the access; a write is dropped, and a read returns rdata=0 with rerr=0.
REQ-022 SHALL return the new data on a read granted in the cycle after a write to the same address, with no stale data.
REQ-023 SHALL not advance the round-robin pointer in a cycle with no requests.
REQ-024 SHALL guarantee that a continuously requesting port is granted within NPORTS cycles.

Reset
REQ-025 SHALL, while rst_n=0, force gnt=0, rvalid=0, rdata=0, rerr=0, and reset the round-robin pointer so that port 0 has highest priority on the first cycle after reset.
REQ-026 SHALL leave memory contents uninitialised by reset.
REQ-027 SHALL discard a read in flight when reset is asserted mid-operation: no rvalid after release.

Configuration
REQ-028 SHALL, when macro TDM_RAM_PARITY_EN is defined, store one even-parity bit per word and, on a read, set rerr=1 together with rvalid if the stored parity mismatches.
REQ-029 SHALL, when TDM_RAM_PARITY_EN is not defined, store no parity bit and tie rerr to 0.

Structure
REQ-030 SHALL place the parity-function helper and the default-parameter constants in shared package tdm_ram_pkg.
REQ-031 SHALL instantiate the arbiter as sub-module rr_arbiter (parameter N; inputs clk, rst_n, req[N]; output gnt[N]), containing the round-robin pointer.
REQ-032 SHALL model the memory array behaviourally inside tdm_multiport_ram with 1-cycle registered read.

Verification
REQ-033 SHALL cover directed write/read: port0 writes 0x55 at 0x00; port1 writes 0xAA at 0x01; port1 reads 0x01 -> rvalid=2'b10 and rdata=0xAA one cycle later.
REQ-034 SHALL cover contention: both ports request every cycle for 6 cycles from reset -> gnt sequence 01,10,01,10,01,10.
REQ-035 SHALL cover read-after-write: port0 writes 0x5A at 0x02, then port1 reads 0x02 in the next cycle -> rdata=0x5A, rvalid=2'b10.
REQ-036 SHALL cover range check with DEPTH=200: write 0x77 at 0xC8, then read 0xC8 -> rdata=0x00, rerr=0.
REQ-037 SHALL cover reset mid-read: read granted, rst_n pulled low before the next edge -> rvalid stays 0, rdata=0, and port0 is granted first after release.
REQ-038 SHALL cover parity, with TDM_RAM_PARITY_EN defined: the bench flips one stored data bit by hierarchical deposit, then reads -> rerr=1 with rvalid; without the macro, rerr=0.
